alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arithmetic ops and an optional iterative multiplier.
// Define ALU_SEQ_MUL_EN to build the shift-add MUL opcode (1000); otherwise 1000 behaves as undefined.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] out,
  output logic             Cout,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         MSB    = WIDTH - 1;

  logic             w_accept;
  logic             w_startMul;
  logic [WIDTH:0]   w_addSum;
  logic [WIDTH:0]   w_subSum;
  logic             w_addOvf;
  logic             w_subOvf;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_v;

  assign w_accept = start & ~busy;

  assign w_addSum = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
  assign w_subSum = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};
  assign w_addOvf = (X[MSB] == Y[MSB]) & (w_addSum[MSB] != X[MSB]);
  assign w_subOvf = (X[MSB] != Y[MSB]) & (w_subSum[MSB] != X[MSB]);

  assign w_lt = $signed(X) < $signed(Y);
  assign w_eq = (X == Y);
  assign w_gt = ~w_lt & ~w_eq;

  // Result of every single-cycle opcode; anything unlisted (including MUL) yields zeros.
  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_v    = 1'b0;
    case (opcode)
      OP_AND: w_res = X & Y;
      OP_OR:  w_res = X | Y;
      OP_NOR: w_res = ~(X | Y);
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      OP_ADD: begin
        w_res  = w_addSum[WIDTH-1:0];
        w_cout = w_addSum[WIDTH];
        w_v    = w_addOvf;
      end
      OP_SUB: begin
        w_res  = w_subSum[WIDTH-1:0];
        w_cout = w_subSum[WIDTH];
        w_v    = w_subOvf;
      end
      default: begin
        w_res  = '0;
        w_cout = 1'b0;
        w_v    = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_nextState;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_cmpLt;
  logic               r_cmpEq;
  logic               r_cmpGt;
  logic [2*WIDTH-1:0] w_accNext;
  logic               w_mulLast;

  assign w_startMul = w_accept & (opcode == OP_MUL);
  assign w_accNext  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mulLast  = (r_state == S_MUL) & (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_startMul) w_nextState = S_MUL;
      S_MUL:   if (w_mulLast)  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_MUL);
  end

  // One multiplier bit per cycle; compare flags are held until the product is published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cmpLt  <= 1'b0;
      r_cmpEq  <= 1'b0;
      r_cmpGt  <= 1'b0;
    end else if (w_startMul) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, X};
      r_mplier <= Y;
      r_cmpLt  <= w_lt;
      r_cmpEq  <= w_eq;
      r_cmpGt  <= w_gt;
    end else if (r_state == S_MUL) begin
      r_count  <= r_count + CW'(1);
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign w_startMul = 1'b0;
  assign busy       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
      lt   <= 1'b0;
      eq   <= 1'b0;
      gt   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept && !w_startMul) begin
        out  <= w_res;
        Cout <= w_cout;
        V    <= w_v;
        lt   <= w_lt;
        eq   <= w_eq;
        gt   <= w_gt;
        done <= 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      if (w_mulLast) begin
        out  <= w_accNext[WIDTH-1:0];
        Cout <= 1'b0;
        V    <= |w_accNext[2*WIDTH-1:WIDTH];
        lt   <= r_cmpLt;
        eq   <= r_cmpEq;
        gt   <= r_cmpGt;
        done <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed self-checking bench for alu_seq at WIDTH=16.
// Expected results come from a plain-arithmetic model; MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Cin;
  logic [W-1:0] out;
  logic         Cout;
  logic         lt;
  logic         eq;
  logic         gt;
  logic         V;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] lastOut = '0;

  typedef struct {
    logic [W-1:0] out;
    logic cout;
    logic v;
    logic lt;
    logic eq;
    logic gt;
    bit   isMul;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .X(X), .Y(Y), .Cin(Cin),
    .out(out), .Cout(Cout), .lt(lt), .eq(eq), .gt(gt), .V(V), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Reference model: integer arithmetic on the operand values, no bit-level datapath.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic cin);
    exp_t e;
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint c  = cin ? 64'sd1 : 64'sd0;
    longint full;
    longint s;
    e = '{out: '0, cout: 1'b0, v: 1'b0, lt: 1'b0, eq: 1'b0, gt: 1'b0, isMul: 1'b0};
    e.lt = (sx < sy);
    e.eq = (sx == sy);
    e.gt = (sx > sy);
    case (op)
      4'b0000: e.out = x & y;
      4'b0001: e.out = x | y;
      4'b1100: e.out = ~(x | y);
      4'b0111: e.out = (sx < sy) ? 16'd1 : 16'd0;
      4'b0010: begin
        full   = ux + uy + c;
        s      = sx + sy + c;
        e.out  = W'(full);
        e.cout = (full >= 65536);
        e.v    = (s > 32767) || (s < -32768);
      end
      4'b0110: begin
        full   = ux - uy;
        s      = sx - sy;
        e.out  = W'(full);
        e.cout = (ux >= uy);
        e.v    = (s > 32767) || (s < -32768);
      end
`ifdef ALU_SEQ_MUL_EN
      4'b1000: begin
        full    = ux * uy;
        e.out   = W'(full);
        e.v     = (full >= 65536);
        e.isMul = 1'b1;
      end
`endif
      default: e.out = '0;
    endcase
    return e;
  endfunction

  task automatic checkAll(input string pfx, input exp_t e);
    checkOutput({pfx, "_out"},  32'(out),  32'(e.out));
    checkOutput({pfx, "_cout"}, 32'(Cout), 32'(e.cout));
    checkOutput({pfx, "_v"},    32'(V),    32'(e.v));
    checkOutput({pfx, "_lt"},   32'(lt),   32'(e.lt));
    checkOutput({pfx, "_eq"},   32'(eq),   32'(e.eq));
    checkOutput({pfx, "_gt"},   32'(gt),   32'(e.gt));
  endtask

  // Issues one operation and follows it to completion, checking latency and results.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic cin, input bit repulse);
    exp_t e;
    bit earlyDone;
    bit busyLow;
    e = model(op, x, y, cin);
    @(negedge clk);
    start = 1'b1; opcode = op; X = x; Y = y; Cin = cin;
    @(posedge clk); #1;
    start = 1'b0;
    if (!e.isMul) begin
      checkOutput("single_done", 32'(done), 32'd1);
      checkOutput("single_busy", 32'(busy), 32'd0);
      checkAll("single", e);
    end else begin
      checkOutput("mul_busyStart", 32'(busy), 32'd1);
      checkOutput("mul_noDoneStart", 32'(done), 32'd0);
      earlyDone = 1'b0;
      busyLow   = 1'b0;
      for (int c = 1; c <= W; c++) begin
        @(negedge clk);
        if (repulse) begin
          start  = 1'b1;
          opcode = 4'($urandom_range(0, 15));
          X      = W'($urandom);
          Y      = W'($urandom);
          Cin    = 1'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (c < W) begin
          if (done) earlyDone = 1'b1;
          if (!busy) busyLow = 1'b1;
        end
      end
      checkOutput("mul_earlyDone", 32'(earlyDone), 32'd0);
      checkOutput("mul_busyDropped", 32'(busyLow), 32'd0);
      checkOutput("mul_done", 32'(done), 32'd1);
      checkOutput("mul_busyEnd", 32'(busy), 32'd0);
      checkAll("mul", e);
      @(negedge clk);
      @(posedge clk); #1;
      checkOutput("mul_singlePulse", 32'(done), 32'd0);
      checkOutput("mul_hold", 32'(out), 32'(e.out));
    end
    lastOut = e.out;
  endtask

  task automatic idleCheck();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_hold", 32'(out), 32'(lastOut));
  endtask

  task automatic checkZeros(input string pfx);
    checkOutput({pfx, "_out"},  32'(out),  32'd0);
    checkOutput({pfx, "_cout"}, 32'(Cout), 32'd0);
    checkOutput({pfx, "_v"},    32'(V),    32'd0);
    checkOutput({pfx, "_lt"},   32'(lt),   32'd0);
    checkOutput({pfx, "_eq"},   32'(eq),   32'd0);
    checkOutput({pfx, "_gt"},   32'(gt),   32'd0);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
    checkOutput({pfx, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [3:0] ops [8];
    bit sawDone;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0011};
    rst = 1'b1; start = 1'b0; opcode = '0; X = '0; Y = '0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkZeros("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(4'b0010, 16'h0002, 16'h0005, 1'b0, 1'b0);
    applyStimulus(4'b0110, 16'h8000, 16'h0001, 1'b0, 1'b0);
    applyStimulus(4'b0110, 16'h0003, 16'h0008, 1'b1, 1'b0);
    applyStimulus(4'b0000, 16'h0007, 16'h0006, 1'b0, 1'b0);
    applyStimulus(4'b1100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(4'b0111, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(4'b0010, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    applyStimulus(4'b0010, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(4'b0011, 16'h1234, 16'h1234, 1'b1, 1'b0);
    idleCheck();
    applyStimulus(4'b1000, 16'h0100, 16'h0300, 1'b0, 1'b1);
    applyStimulus(4'b1000, 16'h0003, 16'h0005, 1'b0, 1'b0);
    idleCheck();

    applyStimulus(4'b1100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkZeros("asyncRst");
    @(negedge clk);
    rst = 1'b0;
    lastOut = '0;

`ifdef ALU_SEQ_MUL_EN
    @(negedge clk);
    start = 1'b1; opcode = 4'b1000; X = 16'hFFFF; Y = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkZeros("midMulRst");
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk); #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abort_noDone", 32'(sawDone), 32'd0);
    applyStimulus(4'b1000, 16'h0003, 16'h0005, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      applyStimulus(ops[$urandom_range(0, 7)], W'($urandom), W'($urandom), 1'($urandom),
                    1'($urandom_range(0, 1)));
      if ((i % 10) == 9) idleCheck();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
